dot_product_sequencer: RTL
==========================

# dot_product_sequencer

Command-driven sequencer sitting directly upstream of the matrix processor's fused multiply-add unit. It accepts a dot-product command (length, seed) and streams operand pairs into the FMA's `a`/`b`/`seed`/load/enable inputs. After the last pair it captures the FMA's registered accumulator and presents it on a valid/ready result port. One instance drives one FMA lane.

## Interface

**Parameters**
- `WIDTH`, default 32: operand, seed and result width. Must match the FMA.
- `LEN_W`, default 8: width of the command length field. Maximum length is 2^LEN_W − 1.

**Ports**
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: command accepted when both this and `cmd_valid` are high.
- `cmd_len`, in, LEN_W: number of operand pairs, unsigned.
- `cmd_seed`, in, WIDTH: initial accumulator value, signed.
- `op_valid`, in, 1: operand pair offered.
- `op_ready`, out, 1: operand pair accepted when both this and `op_valid` are high.
- `op_a`, `op_b`, in, WIDTH each: operand pair, signed.
- `fma_a`, `fma_b`, out, WIDTH each: to FMA `a`/`b`.
- `fma_seed`, out, WIDTH: to FMA `seed`.
- `fma_load`, out, 1: to FMA `updateAccumulator`.
- `fma_en`, out, 1: to FMA `en`.
- `fma_acc`, in, WIDTH: from FMA `accumulatorOut`.
- `res_valid`, out, 1: result available.
- `res_ready`, in, 1: result consumed when both this and `res_valid` are high.
- `res_data`, out, WIDTH: dot-product result, signed.
- `busy`, out, 1: high whenever state ≠ IDLE.

## Operation

**States:** IDLE, STREAM, DRAIN, HOLD.

**IDLE**
- `cmd_ready` = 1. All other handshake outputs and `fma_en` = 0.
- On a command handshake: latch `seed_reg` ← `cmd_seed` and `remaining` ← `cmd_len`, and set the `first` flag.
- If `cmd_len` = 0: go to HOLD with `res_data` ← `cmd_seed`. The FMA is not touched.
- Otherwise go to STREAM.

**STREAM**
- `op_ready` = 1.
- `fma_en` = `op_valid`.
- `fma_a`/`fma_b` = `op_a`/`op_b`, combinational pass-through, forced to 0 when `fma_en` = 0.
- `fma_load` = `first` & `fma_en`. The first beat computes seed + a·b.
- `fma_seed` = `seed_reg` at all times.
- Each accepted beat clears `first` and decrements `remaining`.
- The beat accepted while `remaining` = 1 moves the state to DRAIN.
- A cycle with `op_valid` low is a bubble: no enable, no state change.

**DRAIN**
- Lasts exactly one cycle. `fma_en` = 0, so the FMA holds its value.
- `res_data` ← `fma_acc`, then go to HOLD.

**HOLD**
- `res_valid` = 1. `res_data` stays stable until the handshake completes.
- On `res_ready`, go to IDLE.
- `cmd_ready` = 0 in HOLD. A new command is accepted no earlier than the cycle after the result handshake.

**Arithmetic**
- This block adds no arithmetic of its own.
- The result is the FMA's modulo-2^WIDTH value: the low WIDTH bits of seed + Σ a·b, in two's complement.

**Boundary conditions**
- `op_valid` while in IDLE, DRAIN or HOLD: ignored, because `op_ready` = 0.
- `cmd_valid` outside IDLE: ignored.
- `cmd_len` = 2^LEN_W − 1: legal. The counter must not wrap before reaching 0.
- The accumulator state left in the FMA by a previous command is irrelevant, because every non-zero command begins with `fma_load`.

**Reset**
- Reset in any state, including mid-stream: the next state is IDLE, `remaining` = 0, `first` = 0, `seed_reg` = 0, `res_data` = 0.
- Any partially streamed command is discarded.
- The FMA's own reset is driven elsewhere. The sequencer does not depend on it.

## Timing

**Reset values and outputs during reset**
- While `rst` is high: `cmd_ready`, `op_ready`, `fma_en`, `fma_load`, `res_valid` and `busy` = 0. `res_data`, `fma_seed`, `fma_a` and `fma_b` = 0.
- `cmd_ready` rises in the first cycle after `rst` deasserts.

**Latency**
- Command accepted at edge t: STREAM begins in cycle t+1, and the first beat can be accepted in that cycle.
- Last beat accepted at edge u: DRAIN in cycle u+1, `res_valid` high from cycle u+2.
- Zero-length command accepted at edge t: `res_valid` high from cycle t+1.

**Throughput**
- Minimum of N + 3 cycles per command with no bubbles and `res_ready` held high. The cycles are: accept, N beats, DRAIN, HOLD.

## Test plan

1. **Basic stream.** WIDTH=32, seed 10, len 3. Pairs (2,3), (4,5), (−1,7) on consecutive cycles, `res_ready`=1.
   - `fma_load` high only on beat 1.
   - `res_data` = 29, with `res_valid` two cycles after the third beat.
2. **Zero length.** len 0, seed −5.
   - `res_valid` the cycle after accept, `res_data` = −5.
   - `fma_en` never asserted.
3. **Backpressure.** len 2 with a 3-cycle `op_valid` bubble between beats, and `res_ready` held low for 4 cycles.
   - No enable during the bubble.
   - `res_data` stable while held; `cmd_ready` = 0 and `busy` = 1 throughout.
4. **Back-to-back commands.** Command A: seed 0, len 1, pair (3,3), giving 9. Command B: seed 1, len 2, pairs (1,1), (2,2).
   - Command B yields 6, proving the load discards the previous accumulator.
5. **Mid-stream reset.** `rst` pulsed after 2 of 4 beats.
   - Next cycle: IDLE, all handshake outputs 0.
   - Then seed 0, len 1, pair (7,6) yields 42.
6. **Overflow wrap.** seed 0x7FFFFFFF, len 1, pair (1,1).
   - `res_data` = 0x80000000.

Source files
------------

// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer
// Takes (length, seed) commands and streams operand pairs into one FMA lane.
// The first beat of every command loads the FMA with seed + a*b, so any value
// left in the accumulator by an earlier command is thrown away. One cycle
// after the last beat, the FMA accumulator is captured and offered on a
// valid/ready result port.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a command
// STREAM | pass accepted operand pairs to the FMA, count down remaining
// DRAIN  | FMA output settles; capture accumulator into res_data
// HOLD   | result offered, waiting for res_ready
module dot_product_sequencer #(
   parameter int WIDTH = 32,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [WIDTH-1:0] cmd_seed,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] fma_a,
   output logic [WIDTH-1:0] fma_b,
   output logic [WIDTH-1:0] fma_seed,
   output logic             fma_load,
   output logic             fma_en,
   input  logic [WIDTH-1:0] fma_acc,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DRAIN  = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   remaining_q, remaining_d;
   logic               first_q, first_d;
   logic [WIDTH-1:0]   seed_q, seed_d;
   logic [WIDTH-1:0]   res_q, res_d;

   // State and datapath registers, synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         first_q     <= 1'b0;
         seed_q      <= '0;
         res_q       <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         first_q     <= first_d;
         seed_q      <= seed_d;
         res_q       <= res_d;
      end
   end

   // Next-state logic and outputs; every output is forced low while rst is high.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      first_d     = first_q;
      seed_d      = seed_q;
      res_d       = res_q;

      cmd_ready   = 1'b0;
      op_ready    = 1'b0;
      fma_en      = 1'b0;
      fma_load    = 1'b0;
      fma_a       = '0;
      fma_b       = '0;
      res_valid   = 1'b0;

      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               seed_d      = cmd_seed;
               remaining_d = cmd_len;
               first_d     = 1'b1;
               if (cmd_len == '0) begin
                  res_d   = cmd_seed;
                  state_d = S_HOLD;
               end else begin
                  state_d = S_STREAM;
               end
            end
         end
         S_STREAM: begin
            op_ready = 1'b1;
            fma_en   = op_valid;
            if (op_valid) begin
               fma_a       = op_a;
               fma_b       = op_b;
               fma_load    = first_q;
               first_d     = 1'b0;
               remaining_d = remaining_q - LEN_W'(1);
               if (remaining_q == LEN_W'(1)) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            res_d   = fma_acc;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      fma_seed = seed_q;
      res_data = res_q;
      busy     = (state_q != S_IDLE);

      if (rst) begin
         cmd_ready = 1'b0;
         op_ready  = 1'b0;
         fma_en    = 1'b0;
         fma_load  = 1'b0;
         fma_a     = '0;
         fma_b     = '0;
         res_valid = 1'b0;
         fma_seed  = '0;
         res_data  = '0;
         busy      = 1'b0;
      end
   end

endmodule
